// File: rtl/fpu_pkg.sv
// Shared FP opcode constants, op descriptor and destination-class decode
// used by the FP decode stage and the FP issue/retire pipeline.
package fpu_pkg;

  localparam int FP_DATA_W = 32;
  localparam int FP_TAG_W  = 5;

  localparam logic [4:0] FMIN   = 5'd0;
  localparam logic [4:0] FMAX   = 5'd1;
  localparam logic [4:0] FSGNJ  = 5'd2;
  localparam logic [4:0] FSGNJN = 5'd3;
  localparam logic [4:0] FSGNJX = 5'd4;
  localparam logic [4:0] FCVTWS = 5'd5;
  localparam logic [4:0] FCVTSW = 5'd6;
  localparam logic [4:0] FCMPEQ = 5'd7;
  localparam logic [4:0] FCMPLT = 5'd8;
  localparam logic [4:0] FCMPLE = 5'd9;
  localparam logic [4:0] FCLASS = 5'd10;

  typedef struct packed {
    logic [4:0]           opcode;
    logic [FP_DATA_W-1:0] a;
    logic [FP_DATA_W-1:0] b;
    logic [2:0]           rnd;
    logic [FP_TAG_W-1:0]  rd;
  } fp_op_t;

  // Results of conversions to integer, compares and classify go to the integer RF.
  function automatic logic is_int_dest(input logic [4:0] opcode);
    logic res;
    case (opcode)
      FCVTWS, FCMPEQ, FCMPLT, FCMPLE, FCLASS: res = 1'b1;
      default:                                res = 1'b0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/pipe_reg_stage.sv
// One valid/ready register slice: loads when empty or when its content
// is being taken downstream, so bubbles collapse through it.
module pipe_reg_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             valid_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             ready_i,
  output logic             valid_o,
  output logic [WIDTH-1:0] data_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             load_en_s;

  assign load_en_s = !valid_q || ready_i;

  // Next-state for the slice: flush wins, otherwise refill on an open slot.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (flush) begin
      valid_d = 1'b0;
    end else if (load_en_s) begin
      valid_d = valid_i;
    end else begin
      valid_d = valid_q;
    end
    if (load_en_s && valid_i) begin
      data_d = data_i;
    end else begin
      data_d = data_q;
    end
  end

  // Slice registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      data_q  <= {WIDTH{1'b0}};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = data_q;

endmodule

// File: rtl/fpu_issue_pipe.sv
// Issue/retire pipeline around the combinational FP misc unit: registered
// operand stage s0 feeding the unit, then PIPE_DEPTH result slices to writeback.
module fpu_issue_pipe
  import fpu_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int TAG_WIDTH  = 5,
  parameter int PIPE_DEPTH = 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [4:0]            in_opcode,
  input  logic [DATA_WIDTH-1:0] in_a,
  input  logic [DATA_WIDTH-1:0] in_b,
  input  logic [2:0]            in_rnd,
  input  logic [TAG_WIDTH-1:0]  in_rd,
  output logic [DATA_WIDTH-1:0] fpu_a,
  output logic [DATA_WIDTH-1:0] fpu_b,
  output logic [2:0]            fpu_rnd,
  output logic [4:0]            fpu_opcode,
  output logic                  fpu_dg_ctrl,
  input  logic [DATA_WIDTH-1:0] fpu_z,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_z,
  output logic [TAG_WIDTH-1:0]  out_rd,
  output logic                  out_to_int,
  output logic                  busy
);

  localparam int RW = DATA_WIDTH + TAG_WIDTH + 1;

  logic                  s0_valid_q, s0_valid_d;
  logic [4:0]            s0_opcode_q, s0_opcode_d;
  logic [DATA_WIDTH-1:0] s0_a_q, s0_a_d;
  logic [DATA_WIDTH-1:0] s0_b_q, s0_b_d;
  logic [2:0]            s0_rnd_q, s0_rnd_d;
  logic [TAG_WIDTH-1:0]  s0_rd_q, s0_rd_d;
  logic                  s0_load_s;

  // Index 0 is s0; index k (1..PIPE_DEPTH) is result slice k.
  logic [PIPE_DEPTH:0]   st_valid;
  logic [RW-1:0]         st_data [0:PIPE_DEPTH];
  // st_open[k]: stage k may load this cycle; st_open[PIPE_DEPTH+1] is writeback.
  logic [PIPE_DEPTH+1:0] st_open;
  logic [PIPE_DEPTH+1:0] tail_full;

  assign st_valid[0] = s0_valid_q;
  assign st_data[0]  = {fpu_z, s0_rd_q, is_int_dest(s0_opcode_q)};

  // Stage k is open unless it and every stage after it are full while writeback stalls;
  // computed from the valid bits directly so ready has no chained combinational loop.
  always_comb begin
    tail_full                = '0;
    st_open                  = '0;
    tail_full[PIPE_DEPTH+1]  = 1'b1;
    st_open[PIPE_DEPTH+1]    = out_ready;
    for (int k = PIPE_DEPTH; k >= 0; k--) begin
      tail_full[k] = tail_full[k+1] & st_valid[k];
      st_open[k]   = out_ready | ~tail_full[k];
    end
  end

  assign in_ready  = !flush && st_open[0];
  assign s0_load_s = in_valid && in_ready;

  // Operand stage next-state.
  always_comb begin
    s0_valid_d  = s0_valid_q;
    s0_opcode_d = s0_opcode_q;
    s0_a_d      = s0_a_q;
    s0_b_d      = s0_b_q;
    s0_rnd_d    = s0_rnd_q;
    s0_rd_d     = s0_rd_q;
    if (flush) begin
      s0_valid_d = 1'b0;
    end else if (st_open[0]) begin
      s0_valid_d = in_valid;
    end else begin
      s0_valid_d = s0_valid_q;
    end
    if (s0_load_s) begin
      s0_opcode_d = in_opcode;
      s0_a_d      = in_a;
      s0_b_d      = in_b;
      s0_rnd_d    = in_rnd;
      s0_rd_d     = in_rd;
    end else begin
      s0_opcode_d = s0_opcode_q;
      s0_a_d      = s0_a_q;
      s0_b_d      = s0_b_q;
      s0_rnd_d    = s0_rnd_q;
      s0_rd_d     = s0_rd_q;
    end
  end

  // Operand stage registers; these drive the FP unit directly.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s0_valid_q  <= 1'b0;
      s0_opcode_q <= 5'd0;
      s0_a_q      <= {DATA_WIDTH{1'b0}};
      s0_b_q      <= {DATA_WIDTH{1'b0}};
      s0_rnd_q    <= 3'd0;
      s0_rd_q     <= {TAG_WIDTH{1'b0}};
    end else begin
      s0_valid_q  <= s0_valid_d;
      s0_opcode_q <= s0_opcode_d;
      s0_a_q      <= s0_a_d;
      s0_b_q      <= s0_b_d;
      s0_rnd_q    <= s0_rnd_d;
      s0_rd_q     <= s0_rd_d;
    end
  end

  for (genvar k = 1; k <= PIPE_DEPTH; k++) begin : g_stage
    pipe_reg_stage #(
      .WIDTH(RW)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .flush   (flush),
      .valid_i (st_valid[k-1]),
      .data_i  (st_data[k-1]),
      .ready_i (st_open[k+1]),
      .valid_o (st_valid[k]),
      .data_o  (st_data[k])
    );
  end

  assign fpu_a       = s0_a_q;
  assign fpu_b       = s0_b_q;
  assign fpu_rnd     = s0_rnd_q;
  assign fpu_opcode  = s0_opcode_q;
  assign fpu_dg_ctrl = s0_valid_q;

  assign out_valid   = st_valid[PIPE_DEPTH];
  assign out_z       = st_data[PIPE_DEPTH][RW-1 -: DATA_WIDTH];
  assign out_rd      = st_data[PIPE_DEPTH][TAG_WIDTH:1];
  assign out_to_int  = st_data[PIPE_DEPTH][0];
  assign busy        = |st_valid;

endmodule

// File: tb/tb_fpu_issue_pipe.sv
// Directed bench for fpu_issue_pipe: a D=1 and a D=3 instance, each fed by a
// small behavioural FP misc unit model.
module tb_fpu_issue_pipe;
  import fpu_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  logic        p1_flush, p1_in_valid, p1_in_ready, p1_fpu_dg_ctrl, p1_out_valid, p1_out_ready;
  logic        p1_out_to_int, p1_busy;
  logic [4:0]  p1_in_opcode, p1_in_rd, p1_fpu_opcode, p1_out_rd;
  logic [2:0]  p1_in_rnd, p1_fpu_rnd;
  logic [31:0] p1_in_a, p1_in_b, p1_fpu_a, p1_fpu_b, p1_fpu_z, p1_out_z;

  logic        p3_flush, p3_in_valid, p3_in_ready, p3_fpu_dg_ctrl, p3_out_valid, p3_out_ready;
  logic        p3_out_to_int, p3_busy;
  logic [4:0]  p3_in_opcode, p3_in_rd, p3_fpu_opcode, p3_out_rd;
  logic [2:0]  p3_in_rnd, p3_fpu_rnd;
  logic [31:0] p3_in_a, p3_in_b, p3_fpu_a, p3_fpu_b, p3_fpu_z, p3_out_z;

  function automatic logic flt(input logic [31:0] a, input logic [31:0] b);
    if (a[31] != b[31]) return a[31];
    else if (!a[31])    return a[30:0] < b[30:0];
    else                return a[30:0] > b[30:0];
  endfunction

  function automatic logic [31:0] fpu_model(input logic [4:0] op, input logic [31:0] a,
                                            input logic [31:0] b);
    case (op)
      FMIN:    return flt(a, b) ? a : b;
      FMAX:    return flt(a, b) ? b : a;
      FSGNJ:   return {b[31], a[30:0]};
      FCMPEQ:  return {31'd0, (a == b)};
      FCMPLT:  return {31'd0, flt(a, b)};
      FCLASS:  return (b == 32'h7F800000) ? 32'h00000080 :
                      (b == 32'hFF800000) ? 32'h00000001 : 32'h00000040;
      default: return 32'd0;
    endcase
  endfunction

  always_comb p1_fpu_z = fpu_model(p1_fpu_opcode, p1_fpu_a, p1_fpu_b);
  always_comb p3_fpu_z = fpu_model(p3_fpu_opcode, p3_fpu_a, p3_fpu_b);

  fpu_issue_pipe #(.DATA_WIDTH(32), .TAG_WIDTH(5), .PIPE_DEPTH(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(p1_flush), .in_valid(p1_in_valid), .in_ready(p1_in_ready),
    .in_opcode(p1_in_opcode), .in_a(p1_in_a), .in_b(p1_in_b), .in_rnd(p1_in_rnd), .in_rd(p1_in_rd),
    .fpu_a(p1_fpu_a), .fpu_b(p1_fpu_b), .fpu_rnd(p1_fpu_rnd), .fpu_opcode(p1_fpu_opcode),
    .fpu_dg_ctrl(p1_fpu_dg_ctrl), .fpu_z(p1_fpu_z), .out_valid(p1_out_valid),
    .out_ready(p1_out_ready), .out_z(p1_out_z), .out_rd(p1_out_rd), .out_to_int(p1_out_to_int),
    .busy(p1_busy)
  );

  fpu_issue_pipe #(.DATA_WIDTH(32), .TAG_WIDTH(5), .PIPE_DEPTH(3)) dut3 (
    .clk(clk), .rst_n(rst_n), .flush(p3_flush), .in_valid(p3_in_valid), .in_ready(p3_in_ready),
    .in_opcode(p3_in_opcode), .in_a(p3_in_a), .in_b(p3_in_b), .in_rnd(p3_in_rnd), .in_rd(p3_in_rd),
    .fpu_a(p3_fpu_a), .fpu_b(p3_fpu_b), .fpu_rnd(p3_fpu_rnd), .fpu_opcode(p3_fpu_opcode),
    .fpu_dg_ctrl(p3_fpu_dg_ctrl), .fpu_z(p3_fpu_z), .out_valid(p3_out_valid),
    .out_ready(p3_out_ready), .out_z(p3_out_z), .out_rd(p3_out_rd), .out_to_int(p3_out_to_int),
    .busy(p3_busy)
  );

  task automatic idle_inputs();
    p1_flush = 1'b0; p1_in_valid = 1'b0; p1_in_opcode = 5'd0; p1_in_a = 32'd0; p1_in_b = 32'd0;
    p1_in_rnd = 3'd0; p1_in_rd = 5'd0; p1_out_ready = 1'b1;
    p3_flush = 1'b0; p3_in_valid = 1'b0; p3_in_opcode = 5'd0; p3_in_a = 32'd0; p3_in_b = 32'd0;
    p3_in_rnd = 3'd0; p3_in_rd = 5'd0; p3_out_ready = 1'b1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle_inputs();
    repeat (2) @(negedge clk);
    total++; if (p1_out_valid !== 1'b0) begin bad++; $display("FAIL reset_p1_out_valid: got %b want 0", p1_out_valid); end
    total++; if (p1_busy !== 1'b0) begin bad++; $display("FAIL reset_p1_busy: got %b want 0", p1_busy); end
    total++; if (p1_out_z !== 32'd0) begin bad++; $display("FAIL reset_p1_out_z: got %h want 0", p1_out_z); end
    total++; if (p1_fpu_a !== 32'd0) begin bad++; $display("FAIL reset_p1_fpu_a: got %h want 0", p1_fpu_a); end
    total++; if (p1_fpu_dg_ctrl !== 1'b0) begin bad++; $display("FAIL reset_p1_dg: got %b want 0", p1_fpu_dg_ctrl); end
    total++; if (p3_out_valid !== 1'b0) begin bad++; $display("FAIL reset_p3_out_valid: got %b want 0", p3_out_valid); end
    total++; if (p3_busy !== 1'b0) begin bad++; $display("FAIL reset_p3_busy: got %b want 0", p3_busy); end
    rst_n = 1'b1;
    #1;
    total++; if (p1_in_ready !== 1'b1) begin bad++; $display("FAIL reset_p1_in_ready: got %b want 1", p1_in_ready); end
    total++; if (p3_in_ready !== 1'b1) begin bad++; $display("FAIL reset_p3_in_ready: got %b want 1", p3_in_ready); end
  endtask

  task automatic test_single_op(input string nm, input logic [4:0] op, input logic [31:0] a,
                                input logic [31:0] b, input logic [4:0] rd,
                                input logic [31:0] exp_z, input logic exp_int);
    @(negedge clk);
    p1_in_valid = 1'b1; p1_in_opcode = op; p1_in_a = a; p1_in_b = b; p1_in_rd = rd;
    p1_in_rnd = 3'd2; p1_out_ready = 1'b1;
    total++; if (p1_in_ready !== 1'b1) begin bad++; $display("FAIL %s_in_ready: got %b want 1", nm, p1_in_ready); end
    @(negedge clk);
    p1_in_valid = 1'b0;
    total++; if (p1_out_valid !== 1'b0) begin bad++; $display("FAIL %s_early_valid: got %b want 0", nm, p1_out_valid); end
    total++; if (p1_fpu_dg_ctrl !== 1'b1) begin bad++; $display("FAIL %s_dg_ctrl: got %b want 1", nm, p1_fpu_dg_ctrl); end
    total++; if (p1_fpu_rnd !== 3'd2) begin bad++; $display("FAIL %s_fpu_rnd: got %0d want 2", nm, p1_fpu_rnd); end
    total++; if (p1_fpu_opcode !== op) begin bad++; $display("FAIL %s_fpu_opcode: got %0d want %0d", nm, p1_fpu_opcode, op); end
    @(negedge clk);
    total++; if (p1_out_valid !== 1'b1) begin bad++; $display("FAIL %s_out_valid: got %b want 1", nm, p1_out_valid); end
    total++; if (p1_out_z !== exp_z) begin bad++; $display("FAIL %s_out_z: got %h want %h", nm, p1_out_z, exp_z); end
    total++; if (p1_out_rd !== rd) begin bad++; $display("FAIL %s_out_rd: got %0d want %0d", nm, p1_out_rd, rd); end
    total++; if (p1_out_to_int !== exp_int) begin bad++; $display("FAIL %s_to_int: got %b want %b", nm, p1_out_to_int, exp_int); end
    @(negedge clk);
    total++; if (p1_out_valid !== 1'b0) begin bad++; $display("FAIL %s_drained: got %b want 0", nm, p1_out_valid); end
    total++; if (p1_busy !== 1'b0) begin bad++; $display("FAIL %s_busy: got %b want 0", nm, p1_busy); end
  endtask

  task automatic test_back_to_back();
    logic [31:0] ea;
    logic [31:0] ez;
    logic [4:0]  erd;
    p1_out_ready = 1'b1;
    for (int c = 0; c < 19; c++) begin
      @(negedge clk);
      if (c >= 2 && c < 18) begin
        ea  = 32'h3F800000 + 32'(c - 2);
        ez  = {ea[0], ea[30:0]};
        erd = 5'(c - 2);
        total++; if (p1_out_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid[%0d]: got %b want 1", c - 2, p1_out_valid); end
        total++; if (p1_out_rd !== erd) begin bad++; $display("FAIL b2b_rd[%0d]: got %0d want %0d", c - 2, p1_out_rd, erd); end
        total++; if (p1_out_z !== ez) begin bad++; $display("FAIL b2b_z[%0d]: got %h want %h", c - 2, p1_out_z, ez); end
      end else begin
        total++; if (p1_out_valid !== 1'b0) begin bad++; $display("FAIL b2b_idle[%0d]: got %b want 0", c, p1_out_valid); end
      end
      if (c < 16) begin
        total++; if (p1_in_ready !== 1'b1) begin bad++; $display("FAIL b2b_in_ready[%0d]: got %b want 1", c, p1_in_ready); end
        ea = 32'h3F800000 + 32'(c);
        p1_in_valid = 1'b1; p1_in_opcode = FSGNJ; p1_in_a = ea;
        p1_in_b = ea[0] ? 32'h80000000 : 32'h00000000; p1_in_rd = 5'(c);
      end else begin
        p1_in_valid = 1'b0;
      end
    end
  endtask

  task automatic test_stall();
    int next_id;
    int n;
    next_id = 0;
    p3_out_ready = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (i == 1) begin
        total++; if (p3_fpu_rnd !== 3'd5) begin bad++; $display("FAIL stall_fpu_rnd: got %0d want 5", p3_fpu_rnd); end
        total++; if (p3_fpu_dg_ctrl !== 1'b1) begin bad++; $display("FAIL stall_dg: got %b want 1", p3_fpu_dg_ctrl); end
      end
      if (i >= 4) begin
        total++; if (p3_out_valid !== 1'b1 || p3_out_rd !== 5'd0 || p3_out_z !== 32'h40000000) begin
          bad++; $display("FAIL stall_hold[%0d]: got v=%b rd=%0d z=%h want v=1 rd=0 z=40000000", i, p3_out_valid, p3_out_rd, p3_out_z);
        end
      end
      p3_in_valid = 1'b1; p3_in_opcode = FMAX; p3_in_a = 32'h40000000 + 32'(next_id);
      p3_in_b = 32'h3F800000; p3_in_rnd = 3'd5; p3_in_rd = 5'(next_id);
      if (p3_in_ready) next_id++;
    end
    total++; if (next_id != 4) begin bad++; $display("FAIL stall_accepts: got %0d want 4", next_id); end
    total++; if (p3_in_ready !== 1'b0) begin bad++; $display("FAIL stall_in_ready: got %b want 0", p3_in_ready); end
    @(negedge clk);
    p3_in_valid = 1'b0; p3_out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 10; c++) begin
      if (p3_out_valid === 1'b1) begin
        total++; if (p3_out_rd !== 5'(n)) begin bad++; $display("FAIL drain_rd[%0d]: got %0d want %0d", n, p3_out_rd, n); end
        total++; if (p3_out_z !== 32'h40000000 + 32'(n)) begin bad++; $display("FAIL drain_z[%0d]: got %h want %h", n, p3_out_z, 32'h40000000 + 32'(n)); end
        n++;
      end
      @(negedge clk);
    end
    total++; if (n != 4) begin bad++; $display("FAIL drain_count: got %0d want 4", n); end
    total++; if (p3_busy !== 1'b0) begin bad++; $display("FAIL drain_busy: got %b want 0", p3_busy); end
  endtask

  task automatic test_flush();
    p3_out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      p3_in_valid = 1'b1; p3_in_opcode = FMIN; p3_in_a = 32'h3F800000; p3_in_b = 32'h40000000;
      p3_in_rd = 5'(10 + i);
    end
    @(negedge clk);
    p3_in_valid = 1'b0; p3_flush = 1'b1;
    #1;
    total++; if (p3_in_ready !== 1'b0) begin bad++; $display("FAIL flush_in_ready: got %b want 0", p3_in_ready); end
    total++; if (p3_busy !== 1'b1) begin bad++; $display("FAIL flush_pre_busy: got %b want 1", p3_busy); end
    @(negedge clk);
    p3_flush = 1'b0;
    total++; if (p3_busy !== 1'b0) begin bad++; $display("FAIL flush_busy: got %b want 0", p3_busy); end
    for (int i = 0; i < 4; i++) begin
      total++; if (p3_out_valid !== 1'b0) begin bad++; $display("FAIL flush_ghost[%0d]: got %b want 0", i, p3_out_valid); end
      @(negedge clk);
    end
    p3_in_valid = 1'b1; p3_in_opcode = FCMPLT; p3_in_a = 32'hBF800000; p3_in_b = 32'h00000000;
    p3_in_rd = 5'd20;
    for (int j = 1; j <= 4; j++) begin
      @(negedge clk);
      p3_in_valid = 1'b0;
      if (j < 4) begin
        total++; if (p3_out_valid !== 1'b0) begin bad++; $display("FAIL post_flush_early[%0d]: got %b want 0", j, p3_out_valid); end
      end else begin
        total++; if (p3_out_valid !== 1'b1 || p3_out_rd !== 5'd20 || p3_out_z !== 32'd1 || p3_out_to_int !== 1'b1) begin
          bad++; $display("FAIL post_flush_op: got v=%b rd=%0d z=%h int=%b want v=1 rd=20 z=1 int=1", p3_out_valid, p3_out_rd, p3_out_z, p3_out_to_int);
        end
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    p3_out_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      p3_in_valid = 1'b1; p3_in_opcode = FMAX; p3_in_a = 32'h41000000; p3_in_b = 32'h3F800000;
      p3_in_rd = 5'(i);
    end
    @(negedge clk);
    p3_in_valid = 1'b0;
    total++; if (p3_out_valid !== 1'b1) begin bad++; $display("FAIL rstmid_full: got %b want 1", p3_out_valid); end
    rst_n = 1'b0;
    #1;
    total++; if (p3_out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_out_valid: got %b want 0", p3_out_valid); end
    total++; if (p3_busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", p3_busy); end
    total++; if (p3_fpu_dg_ctrl !== 1'b0) begin bad++; $display("FAIL rstmid_dg: got %b want 0", p3_fpu_dg_ctrl); end
    total++; if (p3_out_z !== 32'd0) begin bad++; $display("FAIL rstmid_out_z: got %h want 0", p3_out_z); end
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    total++; if (p3_in_ready !== 1'b1) begin bad++; $display("FAIL rstmid_in_ready: got %b want 1", p3_in_ready); end
    @(negedge clk);
    total++; if (p3_out_valid !== 1'b0) begin bad++; $display("FAIL rstmid_after: got %b want 0", p3_out_valid); end
    p3_out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_single_op("fmin",   FMIN,   32'h3F800000, 32'h40000000, 5'd3, 32'h3F800000, 1'b0);
    test_single_op("fcmplt", FCMPLT, 32'hBF800000, 32'h00000000, 5'd7, 32'h00000001, 1'b1);
    test_single_op("fclass", FCLASS, 32'h00000000, 32'h7F800000, 5'd9, 32'h00000080, 1'b1);
    test_single_op("unknown", 5'd31, 32'h12345678, 32'h9ABCDEF0, 5'd30, 32'h00000000, 1'b0);
    test_back_to_back();
    test_stall();
    test_flush();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
